// File: rtl/fp_share_pkg.sv
// Shared definitions for the FMA sharing logic: default sizes, the in-flight
// tag record and the negate-select encodings carried on op_i / fma_op_o.
package fp_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 2;
    localparam int MAX_NUM_REQ = 8;

    // Sized for the largest supported requester count so one tag type serves every instance.
    localparam int TAG_IDX_W = $clog2(MAX_NUM_REQ);

    localparam logic [1:0] OP_FMA    = 2'b00;
    localparam logic [1:0] OP_NEG_C  = 2'b01;
    localparam logic [1:0] OP_NEG_B  = 2'b10;
    localparam logic [1:0] OP_NEG_BC = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the
// last winner; the pointer only moves in cycles that produce a grant.
module fp_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    localparam int             SUM_W = IDX_W + 1;
    localparam logic [IDX_W:0] N_W   = SUM_W'(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   sum;
    logic [IDX_W:0]   nxt;
    logic             found;

    // Grant is forced low while reset is asserted so nothing issues during reset.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + SUM_W'(i);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            cand = sum[IDX_W-1:0];
            if (!found && rst_ni && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_comb begin
        nxt = {1'b0, idx_o} + SUM_W'(1);
        if (nxt >= N_W) begin
            nxt = '0;
        end
        ptr_d = (|gnt_o) ? nxt[IDX_W-1:0] : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_fma_arbiter.sv
// Shares one fixed-latency FMA among NUM_REQ requesters: round-robin issue,
// a tag pipeline matching the FMA latency, and result routing back by tag.
module fp_fma_arbiter
    import fp_share_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int RND_WIDTH  = 2,
    parameter int STAT_WIDTH = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    input  logic [NUM_REQ-1:0][31:0]           opa_i,
    input  logic [NUM_REQ-1:0][31:0]           opb_i,
    input  logic [NUM_REQ-1:0][31:0]           opc_i,
    input  logic [NUM_REQ-1:0][1:0]            op_i,
    input  logic [NUM_REQ-1:0][RND_WIDTH-1:0]  rnd_i,
    output logic [NUM_REQ-1:0]                 rvalid_o,
    output logic [31:0]                        res_o,
    output logic [STAT_WIDTH-1:0]              status_o,
    output logic                               fma_en_o,
    output logic [31:0]                        fma_opa_o,
    output logic [31:0]                        fma_opb_o,
    output logic [31:0]                        fma_opc_o,
    output logic [1:0]                         fma_op_o,
    output logic [RND_WIDTH-1:0]               fma_rnd_o,
    input  logic [31:0]                        fma_res_i,
    input  logic [STAT_WIDTH-1:0]              fma_status_i,
    input  logic                               fma_valid_i,
    output logic                               err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]         gnt_idx;
    tag_t                     tag_d;
    tag_t [LATENCY-1:0]       tag_q;
    tag_t                     tail;
    logic                     err_q;

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i),
        .gnt_o  (gnt_o),
        .idx_o  (gnt_idx)
    );

    // Issue bus is zeroed when idle so the FMA never sees stale operands.
    always_comb begin
        fma_en_o  = |gnt_o;
        fma_opa_o = fma_en_o ? opa_i[gnt_idx] : '0;
        fma_opb_o = fma_en_o ? opb_i[gnt_idx] : '0;
        fma_opc_o = fma_en_o ? opc_i[gnt_idx] : '0;
        fma_op_o  = fma_en_o ? op_i[gnt_idx]  : '0;
        fma_rnd_o = fma_en_o ? rnd_i[gnt_idx] : '0;
        tag_d.valid = fma_en_o;
        tag_d.idx   = TAG_IDX_W'(gnt_idx);
    end

    generate
        if (LATENCY == 1) begin : g_tag_one
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    tag_q <= '0;
                end else begin
                    tag_q <= tag_d;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    tag_q <= '0;
                end else begin
                    tag_q <= {tag_q[LATENCY-2:0], tag_d};
                end
            end
        end
    endgenerate

    assign tail = tag_q[LATENCY-1];

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_route
            assign rvalid_o[k] = tail.valid && (tail.idx == TAG_IDX_W'(k));
        end
    endgenerate

    assign res_o    = fma_res_i;
    assign status_o = fma_status_i;

    // Sticky: a valid from the FMA that disagrees with our tag means the pipe depths differ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (fma_valid_i != tail.valid) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fp_fma_arbiter.sv
// Directed bench for fp_fma_arbiter: a cycle table for arbitration, latency and
// routing, plus hand sequences for the mismatch flag and reset mid-operation.
module tb_fp_fma_arbiter;
    import fp_share_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int RW  = 2;
    localparam int SW  = 5;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [N-1:0]           req_i;
    logic [N-1:0]           gnt_o;
    logic [N-1:0][31:0]     opa_i, opb_i, opc_i;
    logic [N-1:0][1:0]      op_i;
    logic [N-1:0][RW-1:0]   rnd_i;
    logic [N-1:0]           rvalid_o;
    logic [31:0]            res_o;
    logic [SW-1:0]          status_o;
    logic                   fma_en_o;
    logic [31:0]            fma_opa_o, fma_opb_o, fma_opc_o;
    logic [1:0]             fma_op_o;
    logic [RW-1:0]          fma_rnd_o;
    logic [31:0]            fma_res_i;
    logic [SW-1:0]          fma_status_i;
    logic                   fma_valid_i;
    logic                   err_o;

    int n_vectors     = 0;
    int n_miscompares = 0;

    fp_fma_arbiter #(
        .NUM_REQ    (N),
        .LATENCY    (LAT),
        .RND_WIDTH  (RW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .opa_i        (opa_i),
        .opb_i        (opb_i),
        .opc_i        (opc_i),
        .op_i         (op_i),
        .rnd_i        (rnd_i),
        .rvalid_o     (rvalid_o),
        .res_o        (res_o),
        .status_o     (status_o),
        .fma_en_o     (fma_en_o),
        .fma_opa_o    (fma_opa_o),
        .fma_opb_o    (fma_opb_o),
        .fma_opc_o    (fma_opc_o),
        .fma_op_o     (fma_op_o),
        .fma_rnd_o    (fma_rnd_o),
        .fma_res_i    (fma_res_i),
        .fma_status_i (fma_status_i),
        .fma_valid_i  (fma_valid_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [N-1:0] rvalid;
        logic [31:0]  res;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] opa_v(int k);
        return 32'hA000_0000 | 32'(k);
    endfunction
    function automatic logic [31:0] opb_v(int k);
        return 32'hB100_0000 | 32'(k);
    endfunction
    function automatic logic [31:0] opc_v(int k);
        return 32'hC200_0000 | 32'(k);
    endfunction
    function automatic logic [1:0] op_v(int k);
        case (k)
            0:       return OP_FMA;
            1:       return OP_NEG_C;
            2:       return OP_NEG_B;
            default: return OP_NEG_BC;
        endcase
    endfunction
    function automatic logic [RW-1:0] rnd_v(int k);
        return RW'(3 - k);
    endfunction

    function automatic logic [127:0] exp_issue(logic [N-1:0] g);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) begin
                r = {28'b0, opa_v(k), opb_v(k), opc_v(k), op_v(k), rnd_v(k)};
            end
        end
        return r;
    endfunction

    task automatic addVec(input logic [N-1:0] req, input logic [N-1:0] gnt,
                          input logic [N-1:0] rv, input logic [31:0] res);
        vec_t v;
        v.req    = req;
        v.gnt    = gnt;
        v.rvalid = rv;
        v.res    = res;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic fv,
                                 input logic [31:0] res, input logic [SW-1:0] st);
        @(negedge clk_i);
        req_i        = req;
        fma_valid_i  = fv;
        fma_res_i    = res;
        fma_status_i = st;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCycle(input string name, input logic [N-1:0] eg,
                              input logic [N-1:0] erv, input logic eerr);
        checkOutput({name, ".gnt"},    128'(gnt_o),    128'(eg));
        checkOutput({name, ".en"},     128'(fma_en_o), 128'(|eg));
        checkOutput({name, ".issue"},
                    {28'b0, fma_opa_o, fma_opb_o, fma_opc_o, fma_op_o, fma_rnd_o},
                    exp_issue(eg));
        checkOutput({name, ".rvalid"}, 128'(rvalid_o), 128'(erv));
        checkOutput({name, ".res"},    128'({res_o, status_o}), 128'({fma_res_i, fma_status_i}));
        checkOutput({name, ".err"},    128'(err_o),    128'(eerr));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            opa_i[k] = opa_v(k);
            opb_i[k] = opb_v(k);
            opc_i[k] = opc_v(k);
            op_i[k]  = op_v(k);
            rnd_i[k] = rnd_v(k);
        end
        rst_ni       = 1'b0;
        req_i        = 4'b1111;
        fma_valid_i  = 1'b0;
        fma_res_i    = '0;
        fma_status_i = '0;

        // Reset priority sweep, drain, single-cycle latency probe, single requester, skip pattern.
        addVec(4'b1111, 4'b0001, 4'b0000, 32'h0);
        addVec(4'b1111, 4'b0010, 4'b0000, 32'h0);
        addVec(4'b1111, 4'b0100, 4'b0001, 32'h0);
        addVec(4'b1111, 4'b1000, 4'b0010, 32'h0);
        addVec(4'b1111, 4'b0001, 4'b0100, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b1000, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0001, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0000, 32'h0);
        addVec(4'b0100, 4'b0100, 4'b0000, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0000, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0100, 32'h3F80_0000);
        addVec(4'b0000, 4'b0000, 4'b0000, 32'h0);
        addVec(4'b0010, 4'b0010, 4'b0000, 32'h0);
        addVec(4'b0010, 4'b0010, 4'b0000, 32'h0);
        addVec(4'b0010, 4'b0010, 4'b0010, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0010, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0010, 32'h0);
        addVec(4'b1001, 4'b1000, 4'b0000, 32'h0);
        addVec(4'b1001, 4'b0001, 4'b0000, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b1000, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0001, 32'h0);
        addVec(4'b0000, 4'b0000, 4'b0000, 32'h0);

        repeat (2) @(negedge clk_i);
        #2;
        checkCycle("reset", 4'b0000, 4'b0000, 1'b0);

        @(negedge clk_i);
        req_i  = '0;
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, |vecs[i].rvalid,
                          (vecs[i].res != 32'h0) ? vecs[i].res : (32'h5EED_0000 | 32'(i)),
                          SW'(i));
            checkCycle($sformatf("row%0d", i), vecs[i].gnt, vecs[i].rvalid, 1'b0);
        end

        // FMA claims a result while no tag is in flight.
        applyStimulus(4'b0000, 1'b1, 32'hDEAD_BEEF, 5'h1F);
        checkCycle("mismatch_inject", 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 32'h0, 5'h0);
            checkCycle($sformatf("mismatch_hold%0d", i), 4'b0000, 4'b0000, 1'b1);
        end

        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 4'b1111;
        #2;
        checkCycle("err_reset", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk_i);
        req_i  = '0;
        rst_ni = 1'b1;

        // Reset one cycle after an issue from requester 3 must swallow its result.
        applyStimulus(4'b1000, 1'b0, 32'h0, 5'h0);
        checkCycle("midop_issue", 4'b1000, 4'b0000, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 4'b1111;
        #2;
        checkCycle("midop_in_reset", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk_i);
        req_i  = '0;
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b0, 32'h0, 5'h0);
            checkCycle($sformatf("midop_drain%0d", i), 4'b0000, 4'b0000, 1'b0);
        end
        applyStimulus(4'b1111, 1'b0, 32'h0, 5'h0);
        checkCycle("midop_prio0", 4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b0, 32'h0, 5'h0);
        checkCycle("midop_prio1", 4'b0010, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/fp_fma_arbiter.md
FP_FMA_ARBITER -- requirements
Module: fp_fma_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one FMA, range 2..8.
REQ-002 SHALL have parameter LATENCY, default 2: fixed FMA issue-to-result latency in cycles, >=1, equal to the FMA's C_MAC_PIPE_REGS.
REQ-003 SHALL have parameter RND_WIDTH, default 2: rounding-mode width.
REQ-004 SHALL have parameter STAT_WIDTH, default 5: status-flag width.
REQ-005 SHALL have port clk_i  in  1: the only clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_ni  in  1: asynchronous active-low reset.
REQ-007 SHALL have port req_i  in  NUM_REQ: per-requester operation request.
REQ-008 SHALL have port gnt_o  out  NUM_REQ: one-hot grant, combinational from req_i and arbiter state.
REQ-009 SHALL have ports opa_i, opb_i, opc_i  in  NUM_REQ x 32: per-requester operands.
REQ-010 SHALL have port op_i  in  NUM_REQ x 2: per-requester negate select, {neg B, neg C}.
REQ-011 SHALL have port rnd_i  in  NUM_REQ x RND_WIDTH: per-requester rounding mode.
REQ-012 SHALL have port rvalid_o  out  NUM_REQ: one-cycle result-valid pulse to the owning requester.
REQ-013 SHALL have ports res_o  out  32 and status_o  out  STAT_WIDTH: result and flags, broadcast to all requesters.
REQ-014 SHALL have ports fma_en_o  out  1, fma_opa_o/fma_opb_o/fma_opc_o  out  32, fma_op_o  out  2 and fma_rnd_o  out  RND_WIDTH: FMA issue bus.
REQ-015 SHALL have ports fma_res_i  in  32, fma_status_i  in  STAT_WIDTH and fma_valid_i  in  1: FMA return bus.
REQ-016 SHALL have port err_o  out  1: sticky FMA/tag mismatch flag.

Function
REQ-017 SHALL assert at most one gnt_o bit per cycle; gnt_o[k] SHALL be high only if req_i[k] is high.
REQ-018 SHALL arbitrate round-robin: search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0.
REQ-019 SHALL accept a request in any cycle: the handshake completes when req_i[k] and gnt_o[k] are both high; there is no FMA back-pressure.
REQ-020 SHALL drive fma_en_o = |gnt_o and the fma_* issue fields from the granted requester in the same cycle; with no grant, the issue fields SHALL be all zero.
REQ-021 SHALL advance the round-robin pointer only in cycles with a grant.
REQ-022 SHALL push {valid, requester index} into a LATENCY-deep tag shift register every cycle, with valid = fma_en_o.
REQ-023 SHALL drive rvalid_o[idx] = tail.valid and res_o/status_o = fma_res_i/fma_status_i combinationally, giving an issue-to-rvalid latency of exactly LATENCY cycles.
REQ-024 SHALL drive rvalid_o to zero when tail.valid is low.
REQ-025 SHALL return results for back-to-back issues on consecutive cycles, in issue order; throughput is 1 op/cycle.
REQ-026 SHALL set err_o when fma_valid_i != tail.valid and hold it until reset; rvalid_o SHALL still follow the tag.
REQ-027 SHALL keep granting the same requester on consecutive cycles when only that requester requests.

Reset
REQ-028 SHALL, while rst_ni is low, clear the tag register (all valid=0), set the round-robin pointer so requester 0 has highest priority, and clear err_o.
REQ-029 SHALL drop in-flight operations on reset mid-operation: no rvalid_o pulse follows for them after reset release.
REQ-030 SHALL keep gnt_o and fma_en_o low while rst_ni is low.

Structure
REQ-031 SHALL take NUM_REQ/LATENCY defaults, the tag struct {valid, idx[$clog2(NUM_REQ)]} and the op-encoding constants from the shared package fp_share_pkg.
REQ-032 SHALL place the round-robin arbiter in a sub-module fp_rr_arbiter (req, gnt, pointer update on grant).
REQ-033 SHALL contain no arithmetic; operand negation remains in the FMA wrapper.

Verification
REQ-034 SHALL cover reset priority: reset, then req_i=4'b1111 -> gnt_o=0001, 0010, 0100, 1000, 0001 on five successive cycles.
REQ-035 SHALL cover latency and routing: req_i=0100 for one cycle, LATENCY=2, fma_res_i=32'h3F800000 at cycle+2 -> rvalid_o=0100 exactly at cycle+2, res_o=32'h3F800000.
REQ-036 SHALL cover single requester: req_i=0010 held for 3 cycles -> gnt_o=0010 on each cycle, three rvalid_o[1] pulses on consecutive cycles.
REQ-037 SHALL cover the mismatch path: fma_valid_i forced high with an empty tag pipe -> err_o=1, stays 1 until rst_ni low.
REQ-038 SHALL cover reset mid-operation: issue from requester 3, assert rst_ni one cycle later -> no rvalid_o pulse after release, gnt priority restarts at requester 0.
